// File: rtl/uart_apb_arbiter.sv
// Purpose: round-robin two-requester APB master sharing the UART APB slave; one transfer in flight.
// Latency: accept -> SETUP next cycle -> ACCESS; done pulses the cycle after PREADY (3 cycles minimum) or after TIMEOUT ACCESS cycles with err.
// Backpressure: reqN_ready is offered only in IDLE to the granted requester; requesters hold valid and fields until ready.
module uart_apb_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              PRESET,
  // requester 0
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_done,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_err,
  // requester 1
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_done,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_err,
  // APB master side
  output logic              PSELx,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  // Counter is wide enough to hold TIMEOUT so the saturation guard is meaningful.
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             ptr;       // 0: requester 0 wins a tie, 1: requester 1 wins a tie
  logic             gnt_id;    // requester owning the transfer in flight
  logic [CNT_W-1:0] wait_cnt;  // ACCESS cycles already spent without PREADY
  logic             grant0;
  logic             grant1;
  logic             accept;
  logic             finish;
  logic             timeout;

  // State register.
  always_ff @(posedge pclk) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, APB strobes, round-robin grant and completion decode.
  always_comb begin
    state_nxt = state;
    PSELx     = 1'b0;
    PENABLE   = 1'b0;
    grant0    = 1'b0;
    grant1    = 1'b0;
    finish    = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        grant0 = req0_valid && (!req1_valid || !ptr);
        grant1 = req1_valid && (!req0_valid ||  ptr);
        if (grant0 || grant1) begin
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        PSELx     = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        PSELx   = 1'b1;
        PENABLE = 1'b1;
        // PREADY in the last allowed cycle still counts as success.
        if (PREADY) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end else if (wait_cnt == CNT_LAST) begin
          finish    = 1'b1;
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // No handshake may complete while reset is held.
  assign req0_ready = grant0 && !PRESET;
  assign req1_ready = grant1 && !PRESET;
  assign accept     = req0_ready || req1_ready;

  // Request capture, round-robin pointer update and wait-state counter.
  always_ff @(posedge pclk) begin
    if (PRESET) begin
      ptr      <= 1'b0;
      gnt_id   <= 1'b0;
      wait_cnt <= '0;
      PWRITE   <= 1'b0;
      PADDR    <= '0;
      PWDATA   <= '0;
    end else begin
      if (accept) begin
        gnt_id <= grant1;
        ptr    <= ~grant1;  // favour whoever was not just served
        PWRITE <= grant1 ? req1_write : req0_write;
        PADDR  <= grant1 ? req1_addr  : req0_addr;
        PWDATA <= grant1 ? req1_wdata : req0_wdata;
      end
      if (state == SETUP) begin
        wait_cnt <= '0;
      end else if (state == ACCESS && !finish && wait_cnt != CNT_MAX) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end

  // Completion routing: only the granted requester's done/err/rdata change.
  always_ff @(posedge pclk) begin
    if (PRESET) begin
      req0_done  <= 1'b0;
      req1_done  <= 1'b0;
      req0_err   <= 1'b0;
      req1_err   <= 1'b0;
      req0_rdata <= '0;
      req1_rdata <= '0;
    end else begin
      req0_done <= finish && !gnt_id;
      req1_done <= finish &&  gnt_id;
      if (finish && !gnt_id) begin
        req0_err <= timeout;
        if (!timeout && !PWRITE) begin
          req0_rdata <= PRDATA;
        end
      end
      if (finish && gnt_id) begin
        req1_err <= timeout;
        if (!timeout && !PWRITE) begin
          req1_rdata <= PRDATA;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_apb_arbiter.sv
// Purpose: scoreboard bench for uart_apb_arbiter with a programmable-wait APB slave model.
// Latency: expected done cycle is hand-computed per vector and checked by the monitor.
// Backpressure: drivers hold valid and fields until ready, as a requester must.
module tb_uart_apb_arbiter;

  logic        pclk = 1'b0;
  logic        PRESET;
  logic        req0_valid, req0_write, req0_ready, req0_done, req0_err;
  logic [31:0] req0_addr, req0_wdata, req0_rdata;
  logic        req1_valid, req1_write, req1_ready, req1_done, req1_err;
  logic [31:0] req1_addr, req1_wdata, req1_rdata;
  logic        PSELx, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY = 1'b0;

  always #5 pclk = ~pclk;

  uart_apb_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .pclk(pclk), .PRESET(PRESET),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_err(req1_err),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic mon_en = 1'b0;
  logic rst_q  = 1'b0;

  always @(posedge pclk) begin
    cyc   <= cyc + 1;
    rst_q <= PRESET;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave model: read data from a small table indexed by PADDR[7:4]; PREADY rises in
  // ACCESS cycle ready_at (0 = never) and is driven high outside ACCESS to prove it is ignored.
  logic [31:0] mem [16];
  int ready_at = 1;
  int acc_n    = 0;
  assign PRDATA = mem[PADDR[7:4]];

  always @(negedge pclk) begin
    if (PSELx === 1'b1 && PENABLE === 1'b1) begin
      acc_n  = acc_n + 1;
      PREADY = (acc_n == ready_at);
    end else begin
      acc_n  = 0;
      PREADY = 1'b1;
    end
  end

  // Scoreboard.
  typedef struct {
    int          port;
    logic        err;
    logic        upd;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;
  exp_t        sbq[$];
  exp_t        mon_e;
  logic [31:0] mdl_rd0 = '0;
  logic [31:0] mdl_rd1 = '0;

  always @(negedge pclk) begin
    if (rst_q) begin
      mdl_rd0 = '0;
      mdl_rd1 = '0;
    end
    if (req0_done || req1_done) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", {30'b0, req1_done, req0_done}, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        check("done_port", {30'b0, req1_done, req0_done}, (mon_e.port == 0) ? 32'd1 : 32'd2);
        check("done_cycle", cyc, mon_e.cyc);
        if (mon_e.upd) begin
          if (mon_e.port == 0) mdl_rd0 = mon_e.rdata;
          else                 mdl_rd1 = mon_e.rdata;
        end
        check("done_err", {31'b0, (mon_e.port == 0) ? req0_err : req1_err}, {31'b0, mon_e.err});
        check("rdata0", req0_rdata, mdl_rd0);
        check("rdata1", req1_rdata, mdl_rd1);
      end
    end
  end

  // APB protocol checker: idle gap before SETUP, SETUP before ACCESS, fields held through ACCESS.
  logic        prev_psel = 1'b0;
  logic        hold_write;
  logic [31:0] hold_addr, hold_wdata;

  always @(negedge pclk) begin
    if (mon_en) begin
      if (!rst_q) begin
        if (PSELx && !PENABLE) begin
          check("psel_gap", {31'b0, prev_psel}, 32'd0);
          hold_addr  = PADDR;
          hold_wdata = PWDATA;
          hold_write = PWRITE;
        end else if (PSELx && PENABLE) begin
          check("access_after_setup", {31'b0, prev_psel}, 32'd1);
          check("paddr_hold", PADDR, hold_addr);
          check("pwdata_hold", PWDATA, hold_wdata);
          check("pwrite_hold", {31'b0, PWRITE}, {31'b0, hold_write});
        end else begin
          check("penable_idle", {31'b0, PENABLE}, 32'd0);
        end
      end
      prev_psel = PSELx;
    end
  end

  // Driver helpers (all called at a falling edge).
  task automatic drive(input int p, input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      req0_valid = v; req0_write = w; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_write = w; req1_addr = a; req1_wdata = d;
    end
  endtask

  task automatic push_exp(input int p, input logic ee, input logic eu, input logic [31:0] er, input int c);
    exp_t e;
    e.port = p; e.err = ee; e.upd = eu; e.rdata = er; e.cyc = c;
    sbq.push_back(e);
  endtask

  // Issue one request; lat is the hand-computed accept-to-done distance.
  task automatic send_one(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input int rat, input logic ee, input logic eu, input logic [31:0] er,
                          input int lat, input logic push);
    int t;
    t = -1;
    ready_at = rat;
    drive(p, 1'b1, w, a, d);
    for (int n = 0; n < 200; n++) begin
      #1;
      if ((p == 0 && req0_ready) || (p == 1 && req1_ready)) begin
        t = cyc;
        break;
      end
      @(negedge pclk);
    end
    check("accept_seen", (t >= 0) ? 32'd1 : 32'd0, 32'd1);
    if (t >= 0 && push) push_exp(p, ee, eu, er, t + lat);
    @(negedge pclk);
    drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && sbq.size() != 0; n++) @(negedge pclk);
    check("sb_drained", sbq.size(), 32'd0);
  endtask

  // Both requesters held valid; entry i is expected on port bv_port[i], zero wait states.
  int          bv_port  [4];
  logic        bv_write [4];
  logic        bv_upd   [4];
  logic [31:0] bv_addr  [4];
  logic [31:0] bv_wdata [4];
  logic [31:0] bv_rd    [4];

  task automatic run_both(input int n);
    int gp;
    logic got;
    ready_at = 1;
    drive(0, 1'b1, bv_write[0], bv_addr[0], bv_wdata[0]);
    drive(1, 1'b1, bv_write[1], bv_addr[1], bv_wdata[1]);
    for (int i = 0; i < n; i++) begin
      got = 1'b0;
      for (int k = 0; k < 100; k++) begin
        #1;
        if (req0_ready || req1_ready) begin
          got = 1'b1;
          break;
        end
        @(negedge pclk);
      end
      check("both_accept_seen", {31'b0, got}, 32'd1);
      if (!got) break;
      gp = req1_ready ? 1 : 0;
      check("grant_order", gp, bv_port[i]);
      push_exp(gp, 1'b0, bv_upd[i], bv_rd[i], cyc + 3);
      @(negedge pclk);
      if (i + 2 < n) drive(gp, 1'b1, bv_write[i+2], bv_addr[i+2], bv_wdata[i+2]);
      else           drive(gp, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[1] = 32'h0000_00A5;
    mem[2] = 32'h1111_2222;
    mem[3] = 32'h3333_4444;
    mem[4] = 32'h5555_6666;
    mem[5] = 32'h7777_8888;
    mem[6] = 32'h9999_AAAA;

    // Reset with a request pending: ready must stay low.
    PRESET = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge pclk);
    #1;
    check("ready0_in_reset", {31'b0, req0_ready}, 32'd0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    PRESET = 1'b0;
    @(negedge pclk);
    mon_en = 1'b1;
    check("rst_psel",    {31'b0, PSELx},   32'd0);
    check("rst_penable", {31'b0, PENABLE}, 32'd0);
    check("rst_pwrite",  {31'b0, PWRITE},  32'd0);
    check("rst_paddr",   PADDR,            32'd0);
    check("rst_pwdata",  PWDATA,           32'd0);
    check("rst_done",    {30'b0, req1_done, req0_done}, 32'd0);
    check("rst_err",     {30'b0, req1_err, req0_err},   32'd0);
    check("rst_rdata0",  req0_rdata, 32'd0);
    check("rst_rdata1",  req1_rdata, 32'd0);

    // Single read on port 0, zero wait states: done at T+3 with 0xA5.
    send_one(0, 1'b0, 32'h10, 32'h0, 1, 1'b0, 1'b1, 32'h0000_00A5, 3, 1'b1);
    check("t1_psel_setup",    {31'b0, PSELx},   32'd1);
    check("t1_penable_setup", {31'b0, PENABLE}, 32'd0);
    @(negedge pclk);
    check("t1_penable_access", {31'b0, PENABLE}, 32'd1);
    drain();

    // Write on port 1 with 3 wait states: done at T+6, rdata1 untouched.
    send_one(1, 1'b1, 32'h30, 32'h41, 4, 1'b0, 1'b0, 32'h0, 6, 1'b1);
    check("t2_pwrite", {31'b0, PWRITE}, 32'd1);
    check("t2_pwdata", PWDATA, 32'h41);
    check("t2_paddr",  PADDR,  32'h30);
    drain();

    // Both valid for four transfers: strict alternation starting at port 0.
    bv_port[0] = 0; bv_write[0] = 1'b0; bv_addr[0] = 32'h20; bv_wdata[0] = 32'h0;         bv_upd[0] = 1'b1; bv_rd[0] = 32'h1111_2222;
    bv_port[1] = 1; bv_write[1] = 1'b0; bv_addr[1] = 32'h40; bv_wdata[1] = 32'h0;         bv_upd[1] = 1'b1; bv_rd[1] = 32'h5555_6666;
    bv_port[2] = 0; bv_write[2] = 1'b1; bv_addr[2] = 32'h50; bv_wdata[2] = 32'hDEAD_BEEF; bv_upd[2] = 1'b0; bv_rd[2] = 32'h0;
    bv_port[3] = 1; bv_write[3] = 1'b0; bv_addr[3] = 32'h60; bv_wdata[3] = 32'h0;         bv_upd[3] = 1'b1; bv_rd[3] = 32'h9999_AAAA;
    run_both(4);
    drain();

    // Timeout: PREADY never rises; 16 ACCESS cycles, done+err at T+18.
    send_one(0, 1'b0, 32'h10, 32'h0, 0, 1'b1, 1'b0, 32'h0, 18, 1'b1);
    repeat (16) @(negedge pclk);
    check("t4_access16_psel",    {31'b0, PSELx},   32'd1);
    check("t4_access16_penable", {31'b0, PENABLE}, 32'd1);
    @(negedge pclk);
    check("t4_psel_falls", {31'b0, PSELx}, 32'd0);
    drain();
    send_one(0, 1'b0, 32'h60, 32'h0, 2, 1'b0, 1'b1, 32'h9999_AAAA, 4, 1'b1);
    drain();

    // PREADY only in ACCESS cycle 16: success, data captured.
    send_one(0, 1'b0, 32'h30, 32'h0, 16, 1'b0, 1'b1, 32'h3333_4444, 18, 1'b1);
    drain();

    // Reset during ACCESS: no done, bus idles, pointer back to port 0.
    send_one(0, 1'b0, 32'h10, 32'h0, 0, 1'b0, 1'b0, 32'h0, 0, 1'b0);
    @(negedge pclk);
    check("t6_in_access", {31'b0, PENABLE}, 32'd1);
    PRESET = 1'b1;
    @(negedge pclk);
    check("t6_psel_after_rst",    {31'b0, PSELx},   32'd0);
    check("t6_penable_after_rst", {31'b0, PENABLE}, 32'd0);
    check("t6_rdata0_after_rst",  req0_rdata,       32'd0);
    PRESET = 1'b0;
    repeat (2) @(negedge pclk);
    check("t6_no_done", {30'b0, req1_done, req0_done}, 32'd0);
    bv_port[0] = 0; bv_write[0] = 1'b0; bv_addr[0] = 32'h40; bv_wdata[0] = 32'h0;    bv_upd[0] = 1'b1; bv_rd[0] = 32'h5555_6666;
    bv_port[1] = 1; bv_write[1] = 1'b1; bv_addr[1] = 32'h70; bv_wdata[1] = 32'h1234; bv_upd[1] = 1'b0; bv_rd[1] = 32'h0;
    run_both(2);
    drain();

    repeat (3) @(negedge pclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
